lzc_pipe: RTL



---
 rtl/lzc_pipe.sv | 69 ++++++
 1 files changed

// File: rtl/lzc_pipe.sv
// rtl/lzc_pipe.sv - pipelined leading-zero counter with valid/ready flow control
// Pair-encode level then log2(WIDTH)-1 combine levels, one register stage per level.
module lzc_pipe #(
   parameter  int WIDTH = 32,
   localparam int LVL   = $clog2(WIDTH),
   localparam int CW    = LVL + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [CW-1:0]    out_count,
   output logic             out_zero
);

   logic adv;

   // The whole pipe moves together; an empty output slot never blocks.
   assign adv      = out_ready | ~out_valid;
   assign in_ready = adv;

   genvar k, i;
   for (k = 1; k <= LVL; k++) begin : g_lvl
      localparam int NF = WIDTH >> k;
      localparam int FW = k + 1;

      logic [NF*FW-1:0] d;
      logic [NF*FW-1:0] q;
      logic             vin;
      logic             v;

      if (k == 1) begin : g_enc
         assign vin = in_valid;
         for (i = 0; i < NF; i++) begin : g_pair
            assign d[2*i +: 2] = {~in_data[2*i+1] & ~in_data[2*i],
                                  ~in_data[2*i+1] &  in_data[2*i]};
         end
      end else begin : g_cmb
         assign vin = g_lvl[k-1].v;
         for (i = 0; i < NF; i++) begin : g_fld
            logic [k-1:0] l;
            logic [k-1:0] r;
            assign l = g_lvl[k-1].q[(2*i+1)*k +: k];
            assign r = g_lvl[k-1].q[(2*i)*k +: k];
            // Upper half all-zero means the count continues into the lower half.
            assign d[i*FW +: FW] = l[k-1] ? {l[k-1] & r[k-1], ~r[k-1], r[k-2:0]}
                                          : {1'b0, l};
         end
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            q <= '0;
            v <= 1'b0;
         end else if (adv) begin
            q <= d;
            v <= vin;
         end
      end
   end

   assign out_count = g_lvl[LVL].q;
   assign out_valid = g_lvl[LVL].v;
   assign out_zero  = out_count[CW-1];

endmodule
